// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Frame format is 8N1: one start bit, eight data bits, one stop bit.
package uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int UART_FRAME_BITS    = 10;
    localparam int UART_DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART shifter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEFAULT_DEPTH
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [7:0]  mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign level   = wptr - rptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Show-ahead read: the head entry is always visible to the shifter.
    assign pop_data = mem[rptr[AW-1:0]];

    // Pointer update; reset empties the FIFO and drops any push.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clock) begin
        if (resetb && push_ok) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter with a runtime bit-period divider.
// Frames are sent LSB-first and back-to-back while data is queued.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEFAULT_DEPTH,
    parameter int DIV_W = 16
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic [DIV_W-1:0]       clk_div,
    input  logic                   tx_en,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t      state;
    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] baud_cnt;
    logic [DIV_W-1:0] div_sel;
    logic [2:0]       bit_cnt;
    logic [7:0]       shifter;
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             bit_end;
    logic             can_start;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign in_ready  = !fifo_full;
    assign div_sel   = (clk_div == '0) ? DIV_ONE : clk_div;
    assign bit_end   = (baud_cnt == '0);
    assign can_start = tx_en && !fifo_empty;

    // A new frame is fetched from idle, or at the last stop-bit cycle.
    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = can_start;
            STOP:    pop = bit_end && can_start;
            default: pop = 1'b0;
        endcase
    end

    // Frame sequencer, baud counter, bit counter and output shifter.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            eff_div  <= DIV_ONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= START;
                        busy     <= 1'b1;
                        tx       <= 1'b0;
                        shifter  <= fifo_data;
                        eff_div  <= div_sel;
                        baud_cnt <= div_sel - 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= eff_div - 1'b1;
                        bit_cnt  <= '0;
                        tx       <= shifter[0];
                        shifter  <= shifter >> 1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= eff_div - 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shifter[0];
                            shifter <= shifter >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state    <= START;
                            busy     <= 1'b1;
                            tx       <= 1'b0;
                            shifter  <= fifo_data;
                            eff_div  <= div_sel;
                            baud_cnt <= div_sel - 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: directed scenarios plus random bursts.
// A line monitor decodes each frame and compares it to a queued expectation.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clock    = 1'b0;
    logic             resetb   = 1'b0;
    logic             tx_en    = 1'b0;
    logic             in_valid = 1'b0;
    logic [DIV_W-1:0] clk_div  = 16'd4;
    logic [7:0]       in_data  = 8'h00;
    logic             in_ready;
    logic             tx;
    logic             busy;
    logic [LW-1:0]    level;

    typedef struct {
        logic [7:0] data;
        int         div;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   n_frames = 0;

    always #5 clock = ~clock;

    uart_tx_buffered #(
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .clock    (clock),
        .resetb   (resetb),
        .clk_div  (clk_div),
        .tx_en    (tx_en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .level    (level)
    );

    function automatic int model_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One push handshake; the model decides whether it is accepted.
    task automatic push_byte(input logic [7:0] d, input bit accept,
                             input int div);
        in_data  = d;
        in_valid = 1'b1;
        if (accept) exp_q.push_back('{data: d, div: div});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic measure(input int probe, output int n, output logic ptx);
        bit seen;
        seen = 1'b0;
        n    = 0;
        ptx  = 1'b1;
        for (int w = 0; w < 3000; w++) begin
            @(negedge clock);
            if (busy === 1'b1) begin
                if (n == probe) ptx = tx;
                n++;
                seen = 1'b1;
            end else if (seen || w > 5) begin
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int w = 0; w < 5000; w++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 64'(done), 64'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic watch_idle(input string name, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            @(negedge clock);
            if (busy !== 1'b0 || tx !== 1'b1) hits++;
        end
        check(name, 64'(hits), 64'd0);
        @(posedge clock);
        #1;
    endtask

    // Line monitor: decode every frame cycle by cycle against the queue.
    exp_t       mon_e;
    int         mon_errs;
    int         mon_b;
    bit         mon_abort;
    logic       mon_bit;
    logic [7:0] mon_got;

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (resetb === 1'b1 && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got start bit, required idle line");
                    while (resetb === 1'b1 && tx === 1'b0) @(negedge clock);
                end else begin
                    mon_e     = exp_q.pop_front();
                    mon_errs  = 0;
                    mon_abort = 1'b0;
                    mon_got   = 8'h00;
                    for (int i = 0; i < 10 * mon_e.div; i++) begin
                        if (i > 0) @(negedge clock);
                        if (resetb !== 1'b1) begin
                            mon_abort = 1'b1;
                            break;
                        end
                        mon_b = i / mon_e.div;
                        if (mon_b == 0) mon_bit = 1'b0;
                        else if (mon_b == 9) mon_bit = 1'b1;
                        else mon_bit = mon_e.data[mon_b-1];
                        if (tx !== mon_bit || busy !== 1'b1) mon_errs++;
                        if (mon_b >= 1 && mon_b <= 8 &&
                            (i % mon_e.div) == mon_e.div / 2)
                            mon_got[mon_b-1] = tx;
                    end
                    if (!mon_abort) begin
                        n_chk++;
                        n_frames++;
                        if (mon_errs != 0 || mon_got !== mon_e.data) begin
                            n_fail++;
                            $display("FAIL frame: got data 0x%0h with %0d bad cycles, required data 0x%0h div %0d",
                                     mon_got, mon_errs, mon_e.data, mon_e.div);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    int   blen;
    logic btx;
    int   f0;
    int   rn;
    bit   hit;

    initial begin : stim
        // Reset with a push held active: nothing may be queued.
        tx_en    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        resetb   = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
            check("rst_tx", 64'(tx), 64'd1);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_level", 64'(level), 64'd0);
        end
        check("rst_in_ready", 64'(in_ready), 64'd1);
        resetb   = 1'b1;
        in_valid = 1'b0;
        watch_idle("rst_no_frame", 30);
        check("rst_level_after", 64'(level), 64'd0);

        // Single byte 0xA5 at 4 clocks per bit.
        clk_div = 16'd4;
        push_byte(8'hA5, 1'b1, 4);
        check("a5_level_push", 64'(level), 64'd1);
        check("a5_tx_before", 64'(tx), 64'd1);
        @(posedge clock);
        #1;
        check("a5_tx_start", 64'(tx), 64'd0);
        check("a5_busy_start", 64'(busy), 64'd1);
        check("a5_level_pop", 64'(level), 64'd0);
        measure(-1, blen, btx);
        check("a5_busy_len", 64'(blen), 64'd40);
        drain("a5_drain");

        // Back-to-back frames at 3 clocks per bit.
        clk_div = 16'd3;
        push_byte(8'h55, 1'b1, 3);
        push_byte(8'h0F, 1'b1, 3);
        measure(30, blen, btx);
        check("b2b_busy_len", 64'(blen), 64'd60);
        check("b2b_start2_tx", 64'(btx), 64'd0);
        drain("b2b_drain");

        // Fill with transmit disabled; the fifth byte is dropped.
        tx_en   = 1'b0;
        clk_div = 16'd2;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h10 + 8'(i), (i < DEPTH), 2);
            if (i == DEPTH - 1)
                check("full_in_ready", 64'(in_ready), 64'd0);
        end
        check("full_level", 64'(level), 64'd4);
        check("full_in_ready2", 64'(in_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd0);
        f0    = n_frames;
        tx_en = 1'b1;
        drain("full_drain");
        check("full_frames", 64'(n_frames - f0), 64'd4);

        // Divider change mid-frame only affects the following frame.
        clk_div = 16'd4;
        push_byte(8'hC3, 1'b1, 4);
        push_byte(8'h3C, 1'b1, 8);
        cycles(8);
        clk_div = 16'd8;
        drain("div_change_drain");

        // Zero divider behaves as one clock per bit.
        clk_div = 16'd0;
        push_byte(8'h96, 1'b1, 1);
        measure(-1, blen, btx);
        check("div0_busy_len", 64'(blen), 64'd10);
        drain("div0_drain");

        // Enable dropped mid-frame: frame completes, queue waits.
        clk_div = 16'd4;
        push_byte(8'h11, 1'b1, 4);
        push_byte(8'h22, 1'b1, 4);
        cycles(9);
        tx_en = 1'b0;
        cycles(60);
        check("en_drop_busy", 64'(busy), 64'd0);
        check("en_drop_level", 64'(level), 64'd1);
        tx_en = 1'b1;
        drain("en_drop_drain");

        // Reset in the middle of a frame with two bytes queued.
        clk_div = 16'd4;
        push_byte(8'h5A, 1'b1, 4);
        push_byte(8'h5B, 1'b1, 4);
        push_byte(8'h5C, 1'b1, 4);
        cycles(13);
        check("mid_busy_before", 64'(busy), 64'd1);
        check("mid_level_before", 64'(level), 64'd2);
        resetb = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1;
        check("mid_rst_tx", 64'(tx), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_level", 64'(level), 64'd0);
        resetb = 1'b1;
        watch_idle("mid_rst_idle", 50);

        // Random bursts, never more than the FIFO holds.
        for (int r = 0; r < 8; r++) begin
            clk_div = 16'($urandom_range(0, 5));
            rn = $urandom_range(1, DEPTH);
            for (int j = 0; j < rn; j++) begin
                push_byte(8'($urandom), 1'b1, model_div(clk_div));
                cycles($urandom_range(0, 3));
            end
            drain("rand_drain");
        end

        hit = (exp_q.size() == 0);
        check("queue_empty", 64'(hit), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
